// File: rtl/rr_dispatcher_pkg.sv
// Shared helpers for the round-robin dispatcher and related RR blocks.
package rr_dispatcher_pkg;

  // Ceiling log2. Used to size port-index fields from the port count.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_dispatcher_next_sel.sv
// Rotating-priority encoder: picks the first set mask bit after ptr, wrapping modulo N.
module rr_next_sel
  import rr_dispatcher_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   mask,
  output logic [IDW-1:0] sel,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Scan from the farthest candidate down to ptr+1 so the nearest enabled port wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (mask[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// Round-robin fan-out: one input stream spread over N outputs through a one-entry holding stage.
module rr_dispatcher
  import rr_dispatcher_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_bits,
  input  logic [N-1:0]   en_mask,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [W-1:0]   out_bits,
  output logic [IDW-1:0] out_chosen,
  output logic           idle
);

  // Handshake: a transfer happens on any edge where valid and ready are both high.
  // Valid never drops or changes payload/target until that transfer; ready may depend
  // combinationally on the far side's ready but never on valid.

  logic           full_q,   full_d;
  logic [W-1:0]   data_q,   data_d;
  logic [IDW-1:0] target_q, target_d;
  logic [IDW-1:0] ptr_q,    ptr_d;

  logic [IDW-1:0] sel;
  logic           sel_any;
  logic           fire;
  logic           load;

  rr_next_sel #(.N(N)) u_next_sel (
    .ptr  (ptr_q),
    .mask (en_mask),
    .sel  (sel),
    .any  (sel_any)
  );

  // The held item may leave and a new one enter on the same edge: no bubble.
  assign fire     = full_q & out_ready[target_q];
  assign in_ready = sel_any & (~full_q | fire);
  assign load     = in_valid & in_ready;

  always_comb begin
    full_d   = full_q;
    data_d   = data_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    if (load) begin
      full_d   = 1'b1;
      data_d   = in_bits;
      target_d = sel;
      ptr_d    = sel;
    end else if (fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q   <= 1'b0;
      data_q   <= '0;
      target_q <= '0;
      ptr_q    <= IDW'(N - 1);
    end else begin
      full_q   <= full_d;
      data_q   <= data_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
    end
  end

  // Outputs come straight from registers, so an offer is stable until it fires.
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = full_q && (target_q == IDW'(i));
    end
  end

  assign out_bits   = data_q;
  assign out_chosen = target_q;
  assign idle       = ~full_q;

endmodule

// File: tb/tb_rr_dispatcher.sv
// Bench for rr_dispatcher: directed scenarios plus random traffic against a queue-based model.
module tb_rr_dispatcher;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_bits;
  logic [N-1:0]   en_mask;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [W-1:0]   out_bits;
  logic [IDW-1:0] out_chosen;
  logic           idle;

  rr_dispatcher #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bits    (in_bits),
    .en_mask    (en_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_chosen (out_chosen),
    .idle       (idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [IDW+W-1:0] exp_q[$];   // {port, payload} of the item the model says is held
  int               m_ptr;      // port that received the last accepted item
  int               act_ports[$];
  int               exp_ports[$];
  int               total;
  int               bad;
  bit               started;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Next eligible port after p, scanning upward with wraparound; -1 when none.
  function automatic int next_port(input int p, input logic [N-1:0] en);
    for (int k = 1; k <= N; k++) begin
      if (en[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model update on each active edge, using only bench-driven inputs.
  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) begin
      exp_q.delete();
      m_ptr = N - 1;
    end else begin
      logic             fire;
      logic             ld;
      int               p;
      logic [IDW+W-1:0] e;
      fire = 1'b0;
      if (exp_q.size() > 0) begin
        e    = exp_q[0];
        fire = out_ready[e[IDW+W-1:W]];
      end
      ld = in_valid && (en_mask != '0) && (exp_q.size() == 0 || fire);
      if (fire) void'(exp_q.pop_front());
      if (ld) begin
        p     = next_port(m_ptr, en_mask);
        m_ptr = p;
        exp_q.push_back({IDW'(p), in_bits});
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic             exp_rdy;
      logic [IDW+W-1:0] e;
      logic [IDW-1:0]   port;
      if (exp_q.size() == 0) begin
        exp_rdy = (en_mask != '0);
        check("out_valid_empty", 32'(out_valid), 32'd0);
        check("idle_empty", 32'(idle), 32'd1);
      end else begin
        e       = exp_q[0];
        port    = e[IDW+W-1:W];
        exp_rdy = (en_mask != '0) && out_ready[port];
        check("out_valid", 32'(out_valid), 32'(1) << port);
        check("out_bits", 32'(out_bits), 32'(e[W-1:0]));
        check("out_chosen", 32'(out_chosen), 32'(port));
        check("idle_full", 32'(idle), 32'd0);
      end
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if ((out_valid != '0) && out_ready[out_chosen]) act_ports.push_back(int'(out_chosen));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [W-1:0] b,
                       input logic [N-1:0] en, input logic [N-1:0] rdy);
    in_valid  = v;
    in_bits   = b;
    en_mask   = en;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ports(input string nm);
    check({nm, "_count"}, 32'(act_ports.size()), 32'(exp_ports.size()));
    for (int i = 0; i < exp_ports.size(); i++) begin
      if (i < act_ports.size()) check(nm, 32'(act_ports[i]), 32'(exp_ports[i]));
    end
    act_ports.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad = 0;
    started = 1'b0;
    m_ptr = N - 1;
    reset = 1'b1;
    in_valid = 1'b0;
    in_bits = '0;
    en_mask = 4'b1111;
    out_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values straight after reset, before any traffic.
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_out_chosen", 32'(out_chosen), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    reset = 1'b0;

    // 1: all enabled and ready, back-to-back items rotate 0..3, four items in five cycles.
    act_ports.delete();
    cycle(1, 8'hA0, 4'b1111, 4'b1111);
    check("t1_latency", 32'(out_valid), 32'b0001);
    cycle(1, 8'hA1, 4'b1111, 4'b1111);
    cycle(1, 8'hA2, 4'b1111, 4'b1111);
    cycle(1, 8'hA3, 4'b1111, 4'b1111);
    cycle(0, 8'h00, 4'b1111, 4'b1111);
    exp_ports = '{0, 1, 2, 3};
    check_ports("t1_ports");

    // 2: only ports 1 and 3 enabled.
    for (int i = 0; i < 4; i++) cycle(1, 8'hB0 + 8'(i), 4'b1010, 4'b1111);
    cycle(0, 8'h00, 4'b1010, 4'b1111);
    exp_ports = '{1, 3, 1, 3};
    check_ports("t2_ports");

    // 3: park ptr at 0, then B0 to port 1 is stalled for five cycles, then released.
    cycle(1, 8'h11, 4'b0001, 4'b1111);
    cycle(0, 8'h00, 4'b1111, 4'b1111);
    act_ports.delete();
    cycle(1, 8'hB0, 4'b1111, 4'b1101);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'hC0, 4'b1111, 4'b1101);
      check("t3_hold_valid", 32'(out_valid), 32'b0010);
      check("t3_hold_bits", 32'(out_bits), 32'hB0);
    end
    cycle(1, 8'hC0, 4'b1111, 4'b1111);
    cycle(0, 8'h00, 4'b1111, 4'b1111);
    exp_ports = '{1, 2};
    check_ports("t3_ports");

    // 4: nothing enabled.
    for (int i = 0; i < 10; i++) cycle(1, 8'(i), 4'b0000, 4'b1111);
    exp_ports = '{};
    check_ports("t4_ports");

    // 5: item held at port 2, then port 2 is disabled; it must still be delivered there.
    cycle(1, 8'h22, 4'b0010, 4'b1111);
    cycle(0, 8'h00, 4'b1111, 4'b1111);
    act_ports.delete();
    cycle(1, 8'h55, 4'b1111, 4'b1011);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 4'b1011, 4'b1011);
    cycle(0, 8'h00, 4'b1011, 4'b1111);
    exp_ports = '{2};
    check_ports("t5_ports");

    // 6: reset while holding an item for port 2; the next item restarts at port 0.
    cycle(1, 8'h33, 4'b0010, 4'b1111);
    cycle(0, 8'h00, 4'b1111, 4'b1111);
    cycle(1, 8'h66, 4'b1111, 4'b0000);
    check("t6_pre_valid", 32'(out_valid), 32'b0100);
    act_ports.delete();
    reset = 1'b1;
    cycle(0, 8'h00, 4'b1111, 4'b0000);
    reset = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);
    cycle(1, 8'h77, 4'b1111, 4'b1111);
    cycle(0, 8'h00, 4'b1111, 4'b1111);
    exp_ports = '{0};
    check_ports("t6_ports");

    // Random traffic; the monitor checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] en;
      if ($urandom_range(0, 9) == 0) en = '0;
      else en = N'($urandom_range(1, 15));
      cycle(logic'($urandom_range(0, 3) != 0), W'($urandom), en, N'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 4'b1111, 4'b1111);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
